bldc_i2c_master: RTL and testbench

Register-access I2C controller (bus master) for the BLDC PID board: the initiating end of the same I2C link whose responder exposes the PID register file (period reference, Kp/Ki/Kd, override, autotune). A host-side sequencer, or the test harness on the companion board, issues single-byte register writes and reads through a start/done handshake. The block generates START, repeated START, STOP and SCL, and it checks every slave ACK.

---
 rtl/bldc_i2c_master.sv | 214 +++++++++++++++++++++
 tb/tb_bldc_i2c_master.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bldc_i2c_master.sv
// I2C bus master for single-byte register writes and reads on the BLDC PID board.
// Bit cells are four quarter-periods of CLK_DIV clocks; every slave ACK is checked.
module bldc_i2c_master #(
    parameter int unsigned CLK_DIV  = 125,
    parameter logic [6:0]  DEV_ADDR = 7'h2A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       sda_oe,
    output logic       scl
);
    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_TX_BYTE,
        S_TX_ACK,
        S_RSTART,
        S_RX_BYTE,
        S_M_NACK,
        S_STOP,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_q;
    logic [2:0]    r_bit;
    logic [1:0]    r_idx;
    logic [7:0]    r_tx;
    logic [7:0]    r_rx;
    logic          r_rw;
    logic [7:0]    r_addr;
    logic [7:0]    r_wdata;
    logic [7:0]    r_rdata;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_nack;
    logic          r_scl;
    logic          r_oe;

    logic w_tick;
    logic w_end;
    logic w_smp;
    logic w_scl;
    logic w_oe;

    assign w_tick = (r_state != S_IDLE) && (r_state != S_DONE) && (r_cnt == LAST);
    assign w_end  = w_tick && (r_q == 2'd3);
    assign w_smp  = w_tick && (r_q == 2'd2);

    // Bus levels decoded from the current quarter; registered below.
    always_comb begin
        w_scl = 1'b1;
        w_oe  = 1'b0;
        unique case (r_state)
            S_START: w_oe = r_q[1];
            S_TX_BYTE: begin
                w_scl = r_q[1];
                w_oe  = ~r_tx[7];
            end
            S_TX_ACK, S_RX_BYTE, S_M_NACK: w_scl = r_q[1];
            S_RSTART: begin
                w_scl = (r_q != 2'd0);
                w_oe  = (r_q == 2'd3);
            end
            S_STOP: begin
                w_scl = (r_q != 2'd0);
                w_oe  = ~r_q[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_q     <= 2'd0;
            r_bit   <= 3'd0;
            r_idx   <= 2'd0;
            r_tx    <= 8'h00;
            r_rx    <= 8'h00;
            r_rw    <= 1'b0;
            r_addr  <= 8'h00;
            r_wdata <= 8'h00;
            r_rdata <= 8'h00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_nack  <= 1'b0;
            r_scl   <= 1'b1;
            r_oe    <= 1'b0;
        end else begin
            r_scl  <= w_scl;
            r_oe   <= w_oe;
            r_done <= 1'b0;
            if (w_tick || r_state == S_IDLE || r_state == S_DONE)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (r_state == S_IDLE)
                r_q <= 2'd0;
            else if (w_tick)
                r_q <= r_q + 2'd1;
            if (w_smp) begin
                r_nack <= sda_in;
                if (r_state == S_RX_BYTE)
                    r_rx <= {r_rx[6:0], sda_in};
            end
            unique case (r_state)
                S_IDLE: begin
                    // The done cycle itself blocks a new accept.
                    if (start && !r_done) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                        r_rw    <= rw;
                        r_addr  <= reg_addr;
                        r_wdata <= wdata;
                    end
                end
                S_START: begin
                    if (w_end) begin
                        r_state <= S_TX_BYTE;
                        r_tx    <= {DEV_ADDR, 1'b0};
                        r_idx   <= 2'd0;
                        r_bit   <= 3'd0;
                    end
                end
                S_TX_BYTE: begin
                    if (w_end) begin
                        r_tx  <= {r_tx[6:0], 1'b0};
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'd7)
                            r_state <= S_TX_ACK;
                    end
                end
                S_TX_ACK: begin
                    if (w_end) begin
                        if (r_nack) begin
                            r_err   <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            unique case (r_idx)
                                2'd0: begin
                                    r_idx   <= 2'd1;
                                    r_tx    <= r_addr;
                                    r_state <= S_TX_BYTE;
                                end
                                2'd1: begin
                                    if (r_rw) begin
                                        r_state <= S_RSTART;
                                    end else begin
                                        r_idx   <= 2'd2;
                                        r_tx    <= r_wdata;
                                        r_state <= S_TX_BYTE;
                                    end
                                end
                                2'd2: r_state <= S_STOP;
                                default: r_state <= S_RX_BYTE;
                            endcase
                        end
                    end
                end
                S_RSTART: begin
                    if (w_end) begin
                        r_idx   <= 2'd3;
                        r_tx    <= {DEV_ADDR, 1'b1};
                        r_state <= S_TX_BYTE;
                    end
                end
                S_RX_BYTE: begin
                    if (w_end) begin
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_rdata <= r_rx;
                            r_state <= S_M_NACK;
                        end
                    end
                end
                S_M_NACK: if (w_end) r_state <= S_STOP;
                S_STOP:   if (w_end) r_state <= S_DONE;
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign ack_err = r_err;
    assign rdata   = r_rdata;
    assign sda_out = 1'b0;
    assign sda_oe  = r_oe;
    assign scl     = r_scl;
endmodule

// File: tb/tb_bldc_i2c_master.sv
// Bench for bldc_i2c_master: a bus-decoding slave model records what the master sends,
// and expectations come from a transaction-level model of the register protocol.
module tb_bldc_i2c_master;
    localparam int CD = 4;
    localparam int EV_ST = 256;
    localparam int EV_RS = 257;
    localparam int EV_SP = 258;
    localparam int EV_NACK = 259;
    localparam int EV_MACK = 260;
    localparam logic [6:0] DEV = 7'h2A;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       rw;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rdata;
    logic       sda_in;
    logic       sda_out;
    logic       sda_oe;
    logic       scl;

    logic       start2;
    logic       busy2;
    logic       done2;
    logic       ack_err2;
    logic [7:0] rdata2;
    logic       sda_out2;
    logic       sda_oe2;
    logic       scl2;

    logic       s_pull;
    logic       s_present;
    logic [7:0] s_data;

    int n_cmp;
    int n_bad;
    int done_cnt;
    int ev_q[$];
    int exp_q[$];
    logic [7:0] exp_rdata;

    typedef struct {
        logic       rw;
        logic [7:0] ra;
        logic [7:0] wd;
        logic [7:0] sd;
        logic       present;
        int         inj;
        logic       exp_err;
        int         exp_cyc;
    } vec_t;

    vec_t tbl[11];

    assign sda_in = ~(sda_oe | s_pull);

    bldc_i2c_master #(.CLK_DIV(CD), .DEV_ADDR(DEV)) u_dut (
        .clk(clk), .rst(rst_n), .start(start), .rw(rw),
        .reg_addr(reg_addr), .wdata(wdata), .busy(busy), .done(done),
        .ack_err(ack_err), .rdata(rdata), .sda_in(sda_in),
        .sda_out(sda_out), .sda_oe(sda_oe), .scl(scl)
    );

    bldc_i2c_master #(.CLK_DIV(2), .DEV_ADDR(DEV)) u_dut2 (
        .clk(clk), .rst(rst_n), .start(start2), .rw(1'b0),
        .reg_addr(8'h21), .wdata(8'h9E), .busy(busy2), .done(done2),
        .ack_err(ack_err2), .rdata(rdata2), .sda_in(1'b0),
        .sda_out(sda_out2), .sda_oe(sda_oe2), .scl(scl2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    // Slave model: decodes START/STOP/bytes from the bus and answers like the PID board.
    initial begin
        int bc;
        int nb;
        logic [7:0] sh;
        logic in_tx, addr_ok, rd_mode, rd_data;
        logic p_scl, p_sda, scl_c, sda_c;
        bc = 0; nb = 0; sh = 8'h00;
        in_tx = 0; addr_ok = 0; rd_mode = 0; rd_data = 0;
        p_scl = 1; p_sda = 1; s_pull = 0;
        forever begin
            @(negedge clk);
            scl_c = scl;
            sda_c = sda_in;
            if (!rst_n) begin
                in_tx = 0; bc = 0; s_pull = 0; rd_mode = 0; rd_data = 0;
            end else if (scl_c && p_scl && p_sda && !sda_c) begin
                ev_q.push_back(in_tx ? EV_RS : EV_ST);
                in_tx = 1; bc = 0; nb = 0;
                rd_mode = 0; rd_data = 0; addr_ok = 0; s_pull = 0;
            end else if (scl_c && p_scl && !p_sda && sda_c) begin
                ev_q.push_back(EV_SP);
                in_tx = 0; bc = 0; s_pull = 0; rd_mode = 0; rd_data = 0;
            end else if (!p_scl && scl_c) begin
                if (bc < 8) begin
                    sh = {sh[6:0], sda_c};
                end else if (rd_data) begin
                    ev_q.push_back(sda_c ? EV_NACK : EV_MACK);
                    if (sda_c) begin
                        rd_mode = 0;
                        rd_data = 0;
                    end
                end
                bc++;
            end else if (p_scl && !scl_c) begin
                s_pull = 0;
                if (bc == 8) begin
                    ev_q.push_back(int'(sh));
                    if (nb == 0) begin
                        addr_ok = s_present && (sh[7:1] == DEV);
                        rd_mode = addr_ok && sh[0];
                        s_pull = addr_ok;
                    end else if (!rd_mode) begin
                        s_pull = addr_ok;
                    end
                    nb++;
                end else if (bc == 9) begin
                    bc = 0;
                    if (rd_mode) begin
                        rd_data = 1;
                        s_pull = !s_data[7];
                    end
                end else if (rd_data && bc > 0) begin
                    s_pull = !s_data[7 - bc];
                end
            end
            p_scl = scl_c;
            p_sda = sda_c;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int model_cycles(input logic r, input logic present);
        int nbytes;
        int quarters;
        nbytes = !present ? 1 : (r ? 4 : 3);
        quarters = 4 + 36 * nbytes + ((r && present) ? 4 : 0) + 4;
        return quarters * CD + 1;
    endfunction

    task automatic build_exp(input vec_t v);
        exp_q.delete();
        exp_q.push_back(EV_ST);
        exp_q.push_back(int'({DEV, 1'b0}));
        if (v.present) begin
            exp_q.push_back(int'(v.ra));
            if (v.rw) begin
                exp_q.push_back(EV_RS);
                exp_q.push_back(int'({DEV, 1'b1}));
                exp_q.push_back(int'(v.sd));
                exp_q.push_back(EV_NACK);
            end else begin
                exp_q.push_back(int'(v.wd));
            end
        end
        exp_q.push_back(EV_SP);
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        int cyc;
        int d0;
        int nmis;
        int first;
        build_exp(v);
        if (v.rw && v.present) exp_rdata = v.sd;
        s_present = v.present;
        s_data = v.sd;
        ev_q.delete();
        @(negedge clk);
        start = 1'b1; rw = v.rw; reg_addr = v.ra; wdata = v.wd;
        @(negedge clk);
        start = 1'b0; rw = ~v.rw; reg_addr = ~v.ra; wdata = ~v.wd;
        d0 = done_cnt;
        chk({nm, " busy"}, 32'(busy), 32'd1);
        cyc = 0;
        while (!done && cyc < v.exp_cyc + 64) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == v.inj) begin
                start = 1'b1; rw = ~v.rw; reg_addr = ~v.ra; wdata = ~v.wd;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({nm, " done_cycles"}, 32'(cyc), 32'(v.exp_cyc));
        chk({nm, " busy_at_done"}, 32'(busy), 32'd0);
        chk({nm, " ack_err"}, 32'(ack_err), 32'(v.exp_err));
        chk({nm, " rdata"}, 32'(rdata), 32'(exp_rdata));
        nmis = 0;
        first = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= ev_q.size() || ev_q[i] != exp_q[i]) begin
                nmis++;
                if (first < 0) first = i;
            end
        end
        if (ev_q.size() != exp_q.size()) nmis++;
        if (nmis != 0)
            $display("bus events of %s differ from index %0d (%0d seen, %0d expected)",
                     nm, first, ev_q.size(), exp_q.size());
        chk({nm, " bus_events"}, 32'(nmis), 32'd0);
        @(negedge clk);
        chk({nm, " done_pulses"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int cyc;
        int r1;
        int r2;
        logic p;
        n_cmp = 0; n_bad = 0; done_cnt = 0;
        exp_rdata = 8'h00;
        s_present = 1'b1; s_data = 8'h00;
        start = 1'b0; rw = 1'b0; reg_addr = 8'h00; wdata = 8'h00;
        start2 = 1'b0;

        tbl[0] = '{1'b0, 8'h41, 8'h5C, 8'h00, 1'b1, -1, 1'b0, 465};
        tbl[1] = '{1'b1, 8'h42, 8'h00, 8'hA7, 1'b1, -1, 1'b0, 625};
        tbl[2] = '{1'b0, 8'h10, 8'h33, 8'h00, 1'b0, -1, 1'b1, 177};
        tbl[3] = '{1'b1, 8'h11, 8'h00, 8'h5A, 1'b0, -1, 1'b1, 177};
        tbl[4] = '{1'b0, 8'h41, 8'h5C, 8'h00, 1'b1, 10, 1'b0, 465};
        for (int i = 5; i < 11; i++) begin
            tbl[i].rw = 1'($urandom_range(0, 1));
            tbl[i].ra = 8'($urandom_range(0, 255));
            tbl[i].wd = 8'($urandom_range(0, 255));
            tbl[i].sd = 8'($urandom_range(0, 255));
            tbl[i].present = ($urandom_range(0, 3) != 0);
            tbl[i].inj = -1;
            tbl[i].exp_err = !tbl[i].present;
            tbl[i].exp_cyc = model_cycles(tbl[i].rw, tbl[i].present);
        end

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset scl", 32'(scl), 32'd1);
        chk("reset sda_oe", 32'(sda_oe), 32'd0);
        chk("reset sda_out", 32'(sda_out), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset ack_err", 32'(ack_err), 32'd0);
        chk("reset rdata", 32'(rdata), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++)
            run_txn(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of the register-index byte.
        s_present = 1'b1;
        start = 1'b1; rw = 1'b0; reg_addr = 8'h41; wdata = 8'h5C;
        @(negedge clk);
        start = 1'b0;
        repeat (180) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset scl", 32'(scl), 32'd1);
        chk("midreset sda_oe", 32'(sda_oe), 32'd0);
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset rdata", 32'(rdata), 32'd0);
        exp_rdata = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn('{1'b0, 8'h48, 8'h03, 8'h00, 1'b1, -1, 1'b0, 465}, "after_reset");

        // CLK_DIV=2 instance: back-to-back writes, start held across the done cycle.
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("fast busy1", 32'(busy2), 32'd1);
        cyc = 0; r1 = -1; r2 = -1; p = scl2;
        while (!done2 && cyc < 400) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (scl2 && !p) begin
                if (r1 < 0) r1 = cyc;
                else if (r2 < 0) r2 = cyc;
            end
            p = scl2;
        end
        chk("fast done_cycles1", 32'(cyc), 32'd233);
        chk("fast bit_period", 32'(r2 - r1), 32'd8);
        chk("fast ack_err1", 32'(ack_err2), 32'd0);
        start2 = 1'b1;
        @(negedge clk);
        chk("fast ignored_in_done", 32'(busy2), 32'd0);
        @(negedge clk);
        start2 = 1'b0;
        chk("fast busy2", 32'(busy2), 32'd1);
        cyc = 0;
        while (!done2 && cyc < 400) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        chk("fast done_cycles2", 32'(cyc), 32'd233);
        chk("fast sda_out", 32'(sda_out2), 32'd0);
        chk("fast rdata", 32'(rdata2), 32'd0);
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
